// File: rtl/last_pos_scheduler_if.sv
// Bundled request / optimizer / response signals of the last-position scheduler.
// master = scheduler side, slave = requesters, optimizer and response consumer.
interface last_pos_scheduler_if #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 10,
  parameter int TAG_WIDTH  = 4
);
  localparam int SEL_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]                 req_valid;
  logic [NUM_REQ-1:0]                 req_ready;
  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0] req_last_scan_pos;
  logic [NUM_REQ-1:0][TAG_WIDTH-1:0]  req_tag;

  logic                  opt_start;
  logic [ADDR_WIDTH-1:0] opt_last_scan_pos;
  logic [SEL_W-1:0]      opt_sel;
  logic                  opt_done;
  logic [ADDR_WIDTH-1:0] opt_best_last;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [SEL_W-1:0]      rsp_id;
  logic [TAG_WIDTH-1:0]  rsp_tag;
  logic [ADDR_WIDTH-1:0] rsp_best_last;
  logic [15:0]           rsp_cycles;

  modport master (
    input  req_valid, req_last_scan_pos, req_tag, opt_done, opt_best_last, rsp_ready,
    output req_ready, opt_start, opt_last_scan_pos, opt_sel,
           rsp_valid, rsp_id, rsp_tag, rsp_best_last, rsp_cycles
  );

  modport slave (
    output req_valid, req_last_scan_pos, req_tag, opt_done, opt_best_last, rsp_ready,
    input  req_ready, opt_start, opt_last_scan_pos, opt_sel,
           rsp_valid, rsp_id, rsp_tag, rsp_best_last, rsp_cycles
  );
endinterface

// File: rtl/last_pos_scheduler.sv
// Round-robin job scheduler in front of a single last-position optimizer:
// grants one requester, runs the optimizer, returns the result with a cycle count.
module last_pos_scheduler #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 10,
  parameter int TAG_WIDTH  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  last_pos_scheduler_if.master bus,
  output logic                 busy
);
  localparam int SEL_W = $clog2(NUM_REQ);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARB   = 3'd1,
    RUN   = 3'd2,
    RESP  = 3'd3,
    DRAIN = 3'd4
  } state_t;

  state_t                state_r;
  state_t                state_next_s;
  logic [SEL_W-1:0]      last_grant_r;
  logic [SEL_W-1:0]      grant_s;
  logic                  req_any_s;
  logic [NUM_REQ-1:0]    req_ready_s;
  logic [SEL_W-1:0]      sel_r;
  logic [ADDR_WIDTH-1:0] pos_r;
  logic [TAG_WIDTH-1:0]  tag_r;
  logic [ADDR_WIDTH-1:0] best_r;
  logic [15:0]           cycles_r;
  logic                  opt_start_r;
  logic                  rsp_valid_r;
  logic                  busy_r;
  // Set by reset: the optimizer may still sit in its done state from a job we aborted.
  logic                  drain_after_reset_r;

  // First valid index strictly after last, wrapping around NUM_REQ.
  function automatic logic [SEL_W-1:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                               input logic [SEL_W-1:0]   last);
    logic [SEL_W-1:0] pick;
    logic [SEL_W-1:0] idx;
    logic             found;
    pick  = last;
    found = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = SEL_W'((int'(last) + i) % NUM_REQ);
      if (!found && valid[idx]) begin
        pick  = idx;
        found = 1'b1;
      end else begin
        found = found;
      end
    end
    return pick;
  endfunction

  assign req_any_s = |bus.req_valid;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state decode and the one-cycle grant pulse in ARB.
  always_comb begin
    state_next_s = state_r;
    grant_s      = rr_pick(bus.req_valid, last_grant_r);
    req_ready_s  = {NUM_REQ{1'b0}};
    case (state_r)
      IDLE: begin
        if (req_any_s && !(drain_after_reset_r && bus.opt_done)) state_next_s = ARB;
        else                                                     state_next_s = IDLE;
      end
      ARB: begin
        if (req_any_s) begin
          state_next_s         = RUN;
          req_ready_s[grant_s] = 1'b1;
        end else begin
          state_next_s = IDLE;
        end
      end
      RUN: begin
        if (bus.opt_done) state_next_s = RESP;
        else              state_next_s = RUN;
      end
      RESP: begin
        if (rsp_valid_r && bus.rsp_ready) state_next_s = DRAIN;
        else                              state_next_s = RESP;
      end
      DRAIN: begin
        if (!bus.opt_done) state_next_s = IDLE;
        else               state_next_s = DRAIN;
      end
      default: state_next_s = IDLE;
    endcase
  end

  // Job capture, cycle counter and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_r        <= SEL_W'(NUM_REQ - 1);
      sel_r               <= '0;
      pos_r               <= '0;
      tag_r               <= '0;
      best_r              <= '0;
      cycles_r            <= 16'd0;
      opt_start_r         <= 1'b0;
      rsp_valid_r         <= 1'b0;
      busy_r              <= 1'b0;
      drain_after_reset_r <= 1'b1;
    end else begin
      opt_start_r <= (state_next_s == RUN);
      rsp_valid_r <= (state_next_s == RESP);
      busy_r      <= (state_next_s != IDLE);
      if (!bus.opt_done) drain_after_reset_r <= 1'b0;
      case (state_r)
        ARB: begin
          if (req_any_s) begin
            sel_r        <= grant_s;
            pos_r        <= bus.req_last_scan_pos[grant_s];
            tag_r        <= bus.req_tag[grant_s];
            last_grant_r <= grant_s;
            cycles_r     <= 16'd0;
          end
        end
        RUN: begin
          if (cycles_r != 16'hFFFF) cycles_r <= cycles_r + 16'd1;
          if (bus.opt_done)         best_r   <= bus.opt_best_last;
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.req_ready         = req_ready_s;
  assign bus.opt_start         = opt_start_r;
  assign bus.opt_last_scan_pos = pos_r;
  assign bus.opt_sel           = sel_r;
  assign bus.rsp_valid         = rsp_valid_r;
  assign bus.rsp_id            = sel_r;
  assign bus.rsp_tag           = tag_r;
  assign bus.rsp_best_last     = best_r;
  assign bus.rsp_cycles        = cycles_r;
  assign busy                  = busy_r;
endmodule
